counter_checker: RTL

Hardware scoreboard for the 4-bit mode counter: observes the same stimulus the counter receives (`enable`, `mode`, `D`) plus the counter's registered responses (`Q`, `rco`, `load`), runs a cycle-accurate internal reference model, and flags every mismatch. It sits on the consuming side of the counter interface in the verification environment, beside the stimulus generator, and drives pass/fail status and error statistics.

---
 rtl/counter_pkg.sv | 23 ++
 rtl/counter_ref_model.sv | 89 ++++++++
 rtl/counter_checker.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the 4-bit mode counter, its reference model and the
// counter_checker scoreboard.
//   mode_e       : counter mode encodings (up, down-by-1, down-by-3, load)
//   chk_state_e  : checker state machine encodings (IDLE, CHECK, DONE)
// -----------------------------------------------------------------------------
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DN1  = 2'b01,
    MODE_DN3  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    DONE  = 2'b10
  } chk_state_e;

endpackage : counter_pkg

// File: rtl/counter_ref_model.sv
// -----------------------------------------------------------------------------
// counter_ref_model
// Cycle-accurate reference model of the 4-bit mode counter. It advances on
// every rising clk regardless of who consumes it, so it stays in lockstep with
// the real counter. Also reused by the counter's stimulus generator.
//
// Parameters:
//   WIDTH    counter data width
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-low reset (clears all model state)
//   enable   counter enable; 0 holds the count and clears rco/load
//   mode     counter mode (see counter_pkg::mode_e)
//   D        load data for MODE_LOAD
//   exp_Q    expected counter value
//   exp_rco  expected ripple-carry (wrap/borrow of the step just taken)
//   exp_load expected load indicator
// -----------------------------------------------------------------------------
module counter_ref_model
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] exp_Q,
  output logic             exp_rco,
  output logic             exp_load
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] THREE    = WIDTH'(3);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] q_q, q_d;
  logic             rco_q, rco_d;
  logic             load_q, load_d;

  // rco flags the step that wraps: it is computed from the value before the
  // step, so it is registered on the same edge as the wrapped count.
  always_comb begin
    // NOTE: every signal gets a default before the branches so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    q_d    = q_q;
    rco_d  = 1'b0;
    load_d = 1'b0;
    if (enable) begin
      case (mode)
        MODE_UP: begin
          q_d   = q_q + ONE;
          rco_d = (q_q == ALL_ONES);
        end
        MODE_DN1: begin
          q_d   = q_q - ONE;
          rco_d = (q_q == '0);
        end
        MODE_DN3: begin
          q_d   = q_q - THREE;
          rco_d = (q_q < THREE);
        end
        default: begin // MODE_LOAD
          q_d    = D;
          load_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      rco_q  <= 1'b0;
      load_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      q_q    <= q_d;
      rco_q  <= rco_d;
      load_q <= load_d;
    end
  end

  assign exp_Q    = q_q;
  assign exp_rco  = rco_q;
  assign exp_load = load_q;

endmodule : counter_ref_model

// File: rtl/counter_checker.sv
// -----------------------------------------------------------------------------
// counter_checker
// Hardware scoreboard for the 4-bit mode counter. Watches the counter's
// stimulus (enable, mode, D) and registered responses (Q, rco, load), runs
// counter_ref_model alongside and flags every mismatch while in CHECK.
//
// Optional feature: define COUNTER_CHECKER_CAPTURE_EN to add first-error
// capture outputs (first_err_cycle, first_err_Q, first_err_exp_Q).
//
// Parameters:
//   WIDTH        counter data width
//   CNT_W        width of err_count / check_count
//   NUM_CHECKS   comparisons before done; 0 = unlimited
// Ports:
//   clk, reset   clock and asynchronous active-low reset
//   start        arms checking (sampled only in IDLE)
//   enable, mode, D    stimulus as driven to the counter
//   Q, rco, load       counter responses under check
//   exp_Q        reference-model count
//   err          one-cycle pulse per detected mismatch
//   err_sticky   set on first mismatch, cleared only by reset
//   err_count    saturating mismatch count
//   check_count  saturating comparison count
//   done         NUM_CHECKS comparisons completed
//   first_err_*  (capture build only) snapshot of the first mismatch
// -----------------------------------------------------------------------------
module counter_checker
  import counter_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int CNT_W      = 8,
  parameter int NUM_CHECKS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Q,
  input  logic             rco,
  input  logic             load,
  output logic [WIDTH-1:0] exp_Q,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] check_count,
  output logic             done
`ifdef COUNTER_CHECKER_CAPTURE_EN
  ,
  output logic [CNT_W-1:0] first_err_cycle,
  output logic [WIDTH-1:0] first_err_Q,
  output logic [WIDTH-1:0] first_err_exp_Q
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // A target beyond the counter range could never be reached; treat it as
  // unlimited rather than matching a truncated value.
  localparam bit               DONE_EN      = (NUM_CHECKS > 0) &&
                                              (NUM_CHECKS <= (2 ** CNT_W) - 1);
  localparam logic [CNT_W-1:0] NUM_CHECKS_C = CNT_W'(NUM_CHECKS);

  logic [WIDTH-1:0] exp_q_w;
  logic             exp_rco_w;
  logic             exp_load_w;

  counter_ref_model #(
    .WIDTH (WIDTH)
  ) u_ref_model (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mode     (mode),
    .D        (D),
    .exp_Q    (exp_q_w),
    .exp_rco  (exp_rco_w),
    .exp_load (exp_load_w)
  );

  chk_state_e       state_q;
  logic             err_q;
  logic             err_sticky_q;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] check_count_q, check_count_d;
  logic             done_q;

  logic             in_check;
  logic             mismatch;
  logic             last_check;

  assign in_check = (state_q == CHECK);
  assign mismatch = (Q != exp_q_w) | (rco != exp_rco_w) | (load != exp_load_w);

  // Saturating statistics; only CHECK cycles advance them.
  always_comb begin
    check_count_d = check_count_q;
    err_count_d   = err_count_q;
    if (in_check && (check_count_q != CNT_MAX)) check_count_d = check_count_q + CNT_ONE;
    if (in_check && mismatch && (err_count_q != CNT_MAX)) err_count_d = err_count_q + CNT_ONE;
  end

  // Compare against the post-increment count so the final comparison's error
  // and done land on the same edge.
  assign last_check = DONE_EN && in_check && (check_count_d == NUM_CHECKS_C);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      err_q         <= 1'b0;
      err_sticky_q  <= 1'b0;
      err_count_q   <= '0;
      check_count_q <= '0;
      done_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) state_q <= CHECK;
        end
        CHECK: begin
          err_q         <= mismatch;
          err_count_q   <= err_count_d;
          check_count_q <= check_count_d;
          if (mismatch) err_sticky_q <= 1'b1;
          if (last_check) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef COUNTER_CHECKER_CAPTURE_EN
  logic [CNT_W-1:0] first_err_cycle_q;
  logic [WIDTH-1:0] first_err_q_q;
  logic [WIDTH-1:0] first_err_exp_q_q;
  logic             capture;

  // err_sticky_q is still clear only on the first counted mismatch, so the
  // snapshot is taken exactly once and then frozen.
  assign capture = in_check & mismatch & ~err_sticky_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_err_cycle_q <= '0;
      first_err_q_q     <= '0;
      first_err_exp_q_q <= '0;
    end else if (capture) begin
      first_err_cycle_q <= check_count_d;
      first_err_q_q     <= Q;
      first_err_exp_q_q <= exp_q_w;
    end
  end

  assign first_err_cycle = first_err_cycle_q;
  assign first_err_Q     = first_err_q_q;
  assign first_err_exp_Q = first_err_exp_q_q;
`endif

  assign exp_Q       = exp_q_w;
  assign err         = err_q;
  assign err_sticky  = err_sticky_q;
  assign err_count   = err_count_q;
  assign check_count = check_count_q;
  assign done        = done_q;

endmodule : counter_checker
